slice_alu: RTL and testbench

- Multi-cycle, parametrised successor to the CPU's single-cycle 8-bit ALU.
- Computes DATA_W-wide arithmetic, logic and shift operations one SLICE_W-bit slice per cycle, chaining carry/borrow and zero across slices.
- Produces Game Boy style ZNHC flags, with half-carry taken at a configurable bit.
- Sits between the decoder/register file and writeback; valid/ready on both sides so 16-bit ops (ADD HL,rr; INC/DEC rr) and wider datapaths share one narrow adder.

---
 rtl/slice_alu_pkg.sv | 110 +++++++++++
 rtl/slice_alu_unit.sv | 77 +++++++
 rtl/slice_alu.sv | 157 +++++++++++++++
 tb/tb_slice_alu.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/slice_alu_pkg.sv
// Shared definitions for the slice-serial ALU: opcodes, flag indices, FSM states
// and the per-opcode chain-seed and final-flag rules.
package slice_alu_pkg;

    typedef enum logic [3:0] {
        SALU_ADD  = 4'd0,
        SALU_ADC  = 4'd1,
        SALU_SUB  = 4'd2,
        SALU_SBC  = 4'd3,
        SALU_AND  = 4'd4,
        SALU_OR   = 4'd5,
        SALU_XOR  = 4'd6,
        SALU_CP   = 4'd7,
        SALU_INC  = 4'd8,
        SALU_DEC  = 4'd9,
        SALU_SL   = 4'd10,
        SALU_SRL  = 4'd11,
        SALU_SRA  = 4'd12,
        SALU_RL   = 4'd13,
        SALU_RR   = 4'd14,
        SALU_PASS = 4'd15
    } salu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } salu_state_e;

    localparam int unsigned F_Z = 3;
    localparam int unsigned F_N = 2;
    localparam int unsigned F_H = 1;
    localparam int unsigned F_C = 0;

    function automatic logic op_is_shift(input salu_op_e op);
        return (op == SALU_SL) || (op == SALU_SRL) || (op == SALU_SRA) ||
               (op == SALU_RL) || (op == SALU_RR);
    endfunction

    function automatic logic op_msb_first(input salu_op_e op);
        return (op == SALU_SRL) || (op == SALU_SRA) || (op == SALU_RR);
    endfunction

    function automatic logic op_is_sub(input salu_op_e op);
        return (op == SALU_SUB) || (op == SALU_SBC) || (op == SALU_CP) ||
               (op == SALU_DEC);
    endfunction

    // Value of the carry/borrow/shift chain entering the first processed slice.
    function automatic logic chain_seed(input salu_op_e op, input logic a_msb,
                                        input logic cin);
        logic seed;
        seed = 1'b0;
        case (op)
            SALU_ADC, SALU_SBC, SALU_RL, SALU_RR: seed = cin;
            SALU_INC, SALU_DEC:                   seed = 1'b1;
            SALU_SRA:                             seed = a_msb;
            default:                              seed = 1'b0;
        endcase
        return seed;
    endfunction

    function automatic logic [3:0] final_flags(input salu_op_e op,
                                               input logic [3:0] fin,
                                               input logic keep_z,
                                               input logic zacc,
                                               input logic half,
                                               input logic chain);
        logic z, n, h, c;
        z = zacc;
        n = 1'b0;
        h = 1'b0;
        c = 1'b0;
        case (op)
            SALU_ADD, SALU_ADC: begin
                h = half;
                c = chain;
            end
            SALU_SUB, SALU_SBC, SALU_CP: begin
                n = 1'b1;
                h = half;
                c = chain;
            end
            SALU_AND: h = 1'b1;
            SALU_INC: begin
                h = half;
                c = fin[F_C];
            end
            SALU_DEC: begin
                n = 1'b1;
                h = half;
                c = fin[F_C];
            end
            SALU_SL, SALU_SRL, SALU_SRA, SALU_RL, SALU_RR: c = chain;
            SALU_PASS: begin
                z = fin[F_Z];
                n = fin[F_N];
                h = fin[F_H];
                c = fin[F_C];
            end
            default: ;
        endcase
        if (keep_z && ((op == SALU_ADD) || (op == SALU_ADC) ||
                       (op == SALU_INC) || (op == SALU_DEC))) begin
            z = fin[F_Z];
        end
        return {z, n, h, c};
    endfunction

endpackage

// File: rtl/slice_alu_unit.sv
// Combinational SLICE_W-bit ALU slice: add/sub with carry chain, logic ops,
// one-bit shifts with shift chain, half-carry tap and slice-zero detect.
module slice_alu_unit
    import slice_alu_pkg::*;
#(
    parameter int unsigned SLICE_W = 8,
    parameter int unsigned TAP_W   = (SLICE_W > 1) ? $clog2(SLICE_W) : 1
) (
    input  salu_op_e           op_i,
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               carry_i,
    input  logic               shift_i,
    input  logic [TAP_W-1:0]   tap_i,
    output logic [SLICE_W-1:0] res_o,
    output logic               carry_o,
    output logic               shift_o,
    output logic               half_o,
    output logic               zero_o
);

    localparam logic [TAP_W-1:0] TOP_TAP = TAP_W'(SLICE_W - 1);

    logic               sub;
    logic [SLICE_W-1:0] bop;
    logic [SLICE_W-1:0] mask;
    logic [SLICE_W:0]   full;
    logic [SLICE_W:0]   part;
    logic [SLICE_W:0]   part_sh;
    logic [SLICE_W:0]   lcat;
    logic [SLICE_W:0]   rcat;
    logic [SLICE_W-1:0] zsrc;

    always_comb begin
        sub  = op_is_sub(op_i);
        bop  = ((op_i == SALU_INC) || (op_i == SALU_DEC)) ? '0 : b_i;
        mask = {SLICE_W{1'b1}} >> (TOP_TAP - tap_i);
        // Masking both operands to bits [tap:0] makes bit tap+1 of the
        // narrow sum/difference the carry/borrow out of the tap bit.
        if (sub) begin
            full = {1'b0, a_i} - {1'b0, bop} - {{SLICE_W{1'b0}}, carry_i};
            part = {1'b0, a_i & mask} - {1'b0, bop & mask} - {{SLICE_W{1'b0}}, carry_i};
        end else begin
            full = {1'b0, a_i} + {1'b0, bop} + {{SLICE_W{1'b0}}, carry_i};
            part = {1'b0, a_i & mask} + {1'b0, bop & mask} + {{SLICE_W{1'b0}}, carry_i};
        end
        part_sh = part >> tap_i;
        carry_o = full[SLICE_W];
        half_o  = part_sh[1];

        lcat = {a_i, shift_i};
        rcat = {shift_i, a_i} >> 1;

        res_o   = a_i;
        shift_o = 1'b0;
        case (op_i)
            SALU_ADD, SALU_ADC, SALU_SUB, SALU_SBC,
            SALU_INC, SALU_DEC: res_o = full[SLICE_W-1:0];
            SALU_AND:           res_o = a_i & b_i;
            SALU_OR:            res_o = a_i | b_i;
            SALU_XOR:           res_o = a_i ^ b_i;
            SALU_SL, SALU_RL: begin
                res_o   = lcat[SLICE_W-1:0];
                shift_o = a_i[SLICE_W-1];
            end
            SALU_SRL, SALU_SRA, SALU_RR: begin
                res_o   = rcat[SLICE_W-1:0];
                shift_o = a_i[0];
            end
            default:            res_o = a_i;
        endcase

        zsrc   = (op_i == SALU_CP) ? full[SLICE_W-1:0] : res_o;
        zero_o = (zsrc == '0);
    end

endmodule

// File: rtl/slice_alu.sv
// Multi-cycle ALU: one SLICE_W slice per cycle through a shared slice unit,
// with valid/ready handshakes on request and result sides.
module slice_alu
    import slice_alu_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SLICE_W  = 8,
    parameter int unsigned HALF_BIT = 11
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [3:0]        in_flags,
    input  logic              in_keep_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_flags,
    output logic              busy
);

    localparam int unsigned NSLICE = DATA_W / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned TAP_W  = (SLICE_W > 1) ? $clog2(SLICE_W) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(HALF_BIT / SLICE_W);
    localparam logic [TAP_W-1:0] HALF_TAP = TAP_W'(HALF_BIT % SLICE_W);

    salu_state_e       state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    salu_op_e          op_q;
    logic [3:0]        fin_q;
    logic              keep_z_q;
    logic              chain_q;
    logic              zacc_q;
    logic              half_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] out_data_q;
    logic [3:0]        out_flags_q;

    logic [IDX_W-1:0]   sidx;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] u_res;
    logic               u_carry;
    logic               u_shift;
    logic               u_half;
    logic               u_zero;

    logic [DATA_W-1:0] res_d;
    logic              zacc_d;
    logic              half_d;
    logic              chain_d;
    logic [3:0]        flags_d;
    logic              accept;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

    // Right shifts walk slices from the top so the shift chain flows downward.
    always_comb begin
        sidx = op_msb_first(op_q) ? (LAST_IDX - idx_q) : idx_q;
        a_sl = a_q[sidx*SLICE_W +: SLICE_W];
        b_sl = b_q[sidx*SLICE_W +: SLICE_W];
    end

    slice_alu_unit #(
        .SLICE_W (SLICE_W),
        .TAP_W   (TAP_W)
    ) u_unit (
        .op_i    (op_q),
        .a_i     (a_sl),
        .b_i     (b_sl),
        .carry_i (chain_q),
        .shift_i (chain_q),
        .tap_i   (HALF_TAP),
        .res_o   (u_res),
        .carry_o (u_carry),
        .shift_o (u_shift),
        .half_o  (u_half),
        .zero_o  (u_zero)
    );

    always_comb begin
        res_d = res_q;
        res_d[sidx*SLICE_W +: SLICE_W] = u_res;
        zacc_d  = zacc_q & u_zero;
        half_d  = (idx_q == HALF_IDX) ? u_half : half_q;
        chain_d = op_is_shift(op_q) ? u_shift : u_carry;
        flags_d = final_flags(op_q, fin_q, keep_z_q, zacc_d, half_d, chain_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= SALU_ADD;
            fin_q       <= '0;
            keep_z_q    <= 1'b0;
            chain_q     <= 1'b0;
            zacc_q      <= 1'b1;
            half_q      <= 1'b0;
            res_q       <= '0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if ((state_q == ST_DONE) && out_ready) begin
                        state_q <= ST_IDLE;
                    end
                    if (accept) begin
                        state_q  <= ST_BUSY;
                        idx_q    <= '0;
                        a_q      <= in_a;
                        b_q      <= in_b;
                        op_q     <= salu_op_e'(in_op);
                        fin_q    <= in_flags;
                        keep_z_q <= in_keep_z;
                        chain_q  <= chain_seed(salu_op_e'(in_op), in_a[DATA_W-1], in_flags[F_C]);
                        zacc_q   <= 1'b1;
                        half_q   <= 1'b0;
                        res_q    <= '0;
                    end
                end
                ST_BUSY: begin
                    res_q   <= res_d;
                    zacc_q  <= zacc_d;
                    half_q  <= half_d;
                    chain_q <= chain_d;
                    if (idx_q == LAST_IDX) begin
                        state_q     <= ST_DONE;
                        out_data_q  <= res_d;
                        out_flags_q <= flags_d;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slice_alu.sv
// Directed self-checking bench for slice_alu (DATA_W=16, SLICE_W=8, HALF_BIT=11).
module tb_slice_alu;
    import slice_alu_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  in_flags;
    logic        in_keep_z;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_flags;
    logic        busy;

    int total = 0;
    int bad   = 0;

    slice_alu #(
        .DATA_W   (16),
        .SLICE_W  (8),
        .HALF_BIT (11)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_flags  (in_flags),
        .in_keep_z (in_keep_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request for a single cycle, then scramble inputs to prove latching.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f, input logic kz);
        @(negedge clock);
        in_op = op; in_a = a; in_b = b; in_flags = f; in_keep_z = kz; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0; in_op = 4'hF; in_a = 16'h5A5A; in_b = 16'hA5A5;
        in_flags = ~f; in_keep_z = ~kz;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] f, input logic kz,
                       input logic [15:0] exp_d, input logic [3:0] exp_f);
        int lat;
        issue(op, a, b, f, kz);
        wait_valid(lat);
        check({tag, "_lat"}, lat, 2);
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_flags"}, out_flags, exp_f);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({tag, "_drain"}, out_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_flags = '0; in_keep_z = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 16'h0000);
        check("rst_flags", out_flags, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;

        run("add_keepz", SALU_ADD, 16'h0FFF, 16'h0001, 4'b1000, 1'b1, 16'h1000, 4'b1010);
        run("sub",       SALU_SUB, 16'h0000, 16'h0001, 4'b0000, 1'b0, 16'hFFFF, 4'b0111);
        run("sbc",       SALU_SBC, 16'h1000, 16'h0000, 4'b0001, 1'b0, 16'h0FFF, 4'b0110);
        run("adc",       SALU_ADC, 16'hFFFF, 16'h0000, 4'b0001, 1'b0, 16'h0000, 4'b1011);
        run("inc",       SALU_INC, 16'hFFFF, 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b1010);
        run("sra",       SALU_SRA, 16'h8001, 16'h0000, 4'b0000, 1'b0, 16'hC000, 4'b0001);
        run("rr",        SALU_RR,  16'h0001, 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b1001);
        run("rl",        SALU_RL,  16'h8000, 16'h0000, 4'b0001, 1'b0, 16'h0001, 4'b0001);
        run("cp_eq",     SALU_CP,  16'h1234, 16'h1234, 4'b0000, 1'b0, 16'h1234, 4'b1100);
        run("dec",       SALU_DEC, 16'h0000, 16'h0000, 4'b0001, 1'b0, 16'hFFFF, 4'b0111);
        run("pass",      SALU_PASS,16'hABCD, 16'h0000, 4'b0101, 1'b1, 16'hABCD, 4'b0101);
        run("srl",       SALU_SRL, 16'h0102, 16'h0000, 4'b1111, 1'b0, 16'h0081, 4'b0000);

        // Backpressure: result held with out_ready low, then back-to-back accept.
        issue(SALU_XOR, 16'h00FF, 16'h0F0F, 4'b0000, 1'b0);
        wait_valid(lat);
        check("bp_lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_hold_data", out_data, 16'h0FF0);
            check("bp_hold_flags", out_flags, 4'b0000);
            check("bp_hold_ready", in_ready, 1'b0);
            check("bp_hold_valid", out_valid, 1'b1);
        end
        in_op = SALU_AND; in_a = 16'h1234; in_b = 16'hFF34; in_flags = 4'b0000;
        in_keep_z = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp_ready_follow", in_ready, 1'b1);
        @(posedge clock);
        #1;
        in_valid = 1'b0; out_ready = 1'b0; in_a = 16'h0000;
        check("bp_busy", busy, 1'b1);
        check("bp_valid_low", out_valid, 1'b0);
        wait_valid(lat);
        check("bp2_lat", lat, 2);
        check("bp2_data", out_data, 16'h1234);
        check("bp2_flags", out_flags, 4'b0010);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;

        // Reset during BUSY aborts the operation and clears held outputs.
        issue(SALU_ADD, 16'h1234, 16'h1111, 4'b0000, 1'b0);
        check("mid_busy", busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 16'h0000);
        check("mid_rst_flags", out_flags, 4'h0);
        check("mid_rst_ready", in_ready, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("post_rst_no_valid", out_valid, 1'b0);
        end
        check("post_rst_ready", in_ready, 1'b1);
        run("post_rst_add", SALU_ADD, 16'h0001, 16'h0001, 4'b0000, 1'b0, 16'h0002, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
